control_fsm: RTL and testbench

Multi-cycle control unit for the RV32I core: a Moore FSM that sequences fetch, decode, execute, memory and writeback for every instruction. It drives the datapath enables, which are only asserted in the correct cycle. It adds several features: a mem_ready handshake with timeout, byte/half/word loads and stores with sign selection, a correct unsigned branch flag, external-trigger stall at instruction boundaries, and a sticky fault trap. It sits in decode, between the instruction register and the datapath muxes.

---
 rtl/control_fsm.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_control_fsm.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/writeback
// and drives the datapath enables, with a memory-handshake timeout and a sticky fault trap.
module control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int ALU_CTRL_W  = 4,
    parameter int IMM_SRC_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr,
    input  logic                  zero,
    input  logic                  negative,
    input  logic                  ltu,
    input  logic                  trigger,
    input  logic                  mem_ready,
    output logic                  IRWrite,
    output logic                  PCWrite,
    output logic [1:0]            PCSrc,
    output logic [1:0]            ResultSrc,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  ALUSrc,
    output logic [IMM_SRC_W-1:0]  ImmSrc,
    output logic                  RegWrite,
    output logic [1:0]            SizeMode,
    output logic                  LoadSigned,
    output logic                  fault,
    output logic [3:0]            state_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALUWB  = 4'd3,
        S_MEMADR = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWB  = 4'd6,
        S_MEMWR  = 4'd7,
        S_BRANCH = 4'd8,
        S_JAL    = 4'd9,
        S_JALR   = 4'd10,
        S_LUI    = 4'd11,
        S_STALL  = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(4);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = ALU_CTRL_W'(5);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = ALU_CTRL_W'(6);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = ALU_CTRL_W'(7);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(8);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(9);

    localparam logic [IMM_SRC_W-1:0] IMM_I = IMM_SRC_W'(0);
    localparam logic [IMM_SRC_W-1:0] IMM_S = IMM_SRC_W'(1);
    localparam logic [IMM_SRC_W-1:0] IMM_B = IMM_SRC_W'(2);
    localparam logic [IMM_SRC_W-1:0] IMM_U = IMM_SRC_W'(3);
    localparam logic [IMM_SRC_W-1:0] IMM_J = IMM_SRC_W'(4);

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_ALU    = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    // Counter only has to reach MEM_TIMEOUT-1; keep at least one bit when disabled.
    localparam int              CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           state;
    state_t           decode_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;
    logic             branch_taken;
    logic [ALU_CTRL_W-1:0] exec_alu;
    logic [IMM_SRC_W-1:0]  decode_imm;

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign state_o   = state;
    assign timed_out = (MEM_TIMEOUT > 0) && !mem_ready && (wait_cnt == TMO_LAST);

    // Opcode dispatch, including the funct3 encodings that are not legal RV32I.
    always_comb begin
        decode_next = S_TRAP;
        case (opcode)
            OP_R, OP_I: decode_next = S_EXEC;
            OP_LOAD:    decode_next = (funct3 == 3'b011 || funct3[2:1] == 2'b11) ? S_TRAP : S_MEMADR;
            OP_STORE:   decode_next = (funct3 >= 3'b011) ? S_TRAP : S_MEMADR;
            OP_BRANCH:  decode_next = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
            OP_JAL:     decode_next = S_JAL;
            OP_JALR:    decode_next = S_JALR;
            OP_LUI:     decode_next = S_LUI;
            default:    decode_next = S_TRAP;
        endcase
    end

    always_comb begin
        decode_imm = IMM_I;
        case (opcode)
            OP_STORE:  decode_imm = IMM_S;
            OP_BRANCH: decode_imm = IMM_B;
            OP_LUI:    decode_imm = IMM_U;
            OP_JAL:    decode_imm = IMM_J;
            default:   decode_imm = IMM_I;
        endcase
    end

    // instr[30] selects sub only for R-type; for shifts-right it selects sra in both formats.
    always_comb begin
        exec_alu = ALU_ADD;
        case (funct3)
            3'b000:  exec_alu = (opcode == OP_R && instr[30]) ? ALU_SUB : ALU_ADD;
            3'b001:  exec_alu = ALU_SLL;
            3'b010:  exec_alu = ALU_SLT;
            3'b011:  exec_alu = ALU_SLTU;
            3'b100:  exec_alu = ALU_XOR;
            3'b101:  exec_alu = instr[30] ? ALU_SRA : ALU_SRL;
            3'b110:  exec_alu = ALU_OR;
            default: exec_alu = ALU_AND;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = ~zero;
            3'b100:  branch_taken = negative;
            3'b101:  branch_taken = ~negative;
            3'b110:  branch_taken = ltu;
            3'b111:  branch_taken = ~ltu;
            default: branch_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            // NOTE: non-blocking, last assignment wins - the clear below is overridden only
            // by the wait branches that stay put, so every state entry starts the count at 0.
            wait_cnt <= '0;
            case (state)
                S_FETCH: begin
                    if (trigger) begin
                        state <= S_STALL;
                    end else if (mem_ready) begin
                        state <= S_DECODE;
                    end else if (timed_out) begin
                        state <= S_TRAP;
                        fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_STALL: begin
                    if (!trigger) state <= S_FETCH;
                end
                S_DECODE: begin
                    state <= decode_next;
                    if (decode_next == S_TRAP) fault <= 1'b1;
                end
                S_EXEC:   state <= S_ALUWB;
                S_MEMADR: state <= (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
                S_MEMRD: begin
                    if (mem_ready) begin
                        state <= S_MEMWB;
                    end else if (timed_out) begin
                        state <= S_TRAP;
                        fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_MEMWR: begin
                    if (mem_ready) begin
                        state <= S_FETCH;
                    end else if (timed_out) begin
                        state <= S_TRAP;
                        fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_ALUWB, S_MEMWB, S_BRANCH, S_JAL, S_JALR, S_LUI: state <= S_FETCH;
                S_TRAP:   state <= S_TRAP;
                default: begin
                    state <= S_TRAP;
                    fault <= 1'b1;
                end
            endcase
        end
    end

    // Enables are decoded from the state register, qualified by the handshake and ALU flags
    // that belong to the same cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = PC_PLUS4;
        ResultSrc  = RES_ALU;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        ALUControl = ALU_ADD;
        ALUSrc     = 1'b0;
        ImmSrc     = IMM_I;
        RegWrite   = 1'b0;
        SizeMode   = 2'b00;
        LoadSigned = 1'b0;
        // NOTE: gating on rst_n drops every request the instant reset asserts, before the
        // asynchronous state clear is even visible downstream.
        if (rst_n) begin
            SizeMode   = funct3[1:0];
            LoadSigned = ~funct3[2];
            case (state)
                S_FETCH: begin
                    if (!trigger) begin
                        MemRead = 1'b1;
                        if (mem_ready) begin
                            IRWrite = 1'b1;
                            PCWrite = 1'b1;
                        end
                    end
                end
                S_DECODE: ImmSrc = decode_imm;
                S_EXEC, S_ALUWB: begin
                    ALUControl = exec_alu;
                    ALUSrc     = (opcode == OP_I);
                    RegWrite   = (state == S_ALUWB);
                end
                S_MEMADR: begin
                    ALUSrc = 1'b1;
                    ImmSrc = (opcode == OP_STORE) ? IMM_S : IMM_I;
                end
                S_MEMRD:  MemRead = 1'b1;
                S_MEMWB: begin
                    RegWrite  = 1'b1;
                    ResultSrc = RES_MEM;
                end
                S_MEMWR:  MemWrite = 1'b1;
                S_BRANCH: begin
                    ALUControl = ALU_SUB;
                    ImmSrc     = IMM_B;
                    PCWrite    = branch_taken;
                    PCSrc      = PC_BRANCH;
                end
                S_JAL: begin
                    RegWrite  = 1'b1;
                    ResultSrc = RES_PC4;
                    PCWrite   = 1'b1;
                    PCSrc     = PC_BRANCH;
                    ImmSrc    = IMM_J;
                end
                S_JALR: begin
                    ALUSrc    = 1'b1;
                    RegWrite  = 1'b1;
                    ResultSrc = RES_PC4;
                    PCWrite   = 1'b1;
                    PCSrc     = PC_ALU;
                end
                S_LUI: begin
                    ImmSrc    = IMM_U;
                    RegWrite  = 1'b1;
                    ResultSrc = RES_IMM;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-state enables for each instruction class,
// handshake waits, stall, timeout trap, illegal decode and reset behaviour.
module tb_control_fsm;

    localparam int MEM_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        zero = 1'b0;
    logic        negative = 1'b0;
    logic        ltu = 1'b0;
    logic        trigger = 1'b0;
    logic        mem_ready = 1'b1;
    logic        IRWrite, PCWrite, MemRead, MemWrite, ALUSrc, RegWrite, LoadSigned, fault;
    logic [1:0]  PCSrc, ResultSrc, SizeMode;
    logic [3:0]  ALUControl, state_o;
    logic [2:0]  ImmSrc;

    int n_checks = 0;
    int n_fail   = 0;

    control_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .ALU_CTRL_W(4), .IMM_SRC_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .negative(negative),
        .ltu(ltu), .trigger(trigger), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .ResultSrc(ResultSrc),
        .MemRead(MemRead), .MemWrite(MemWrite), .ALUControl(ALUControl), .ALUSrc(ALUSrc),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .SizeMode(SizeMode), .LoadSigned(LoadSigned),
        .fault(fault), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 2 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        trigger   = 1'b0;
        #1;
        check("rst_state", state_o, 0);
        check("rst_fault", fault, 0);
        check("rst_memread", MemRead, 0);
        check("rst_irwrite", IRWrite, 0);
        check("rst_pcwrite", PCWrite, 0);
        check("rst_loadsigned", LoadSigned, 0);
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    // Zero-wait fetch of one instruction; returns in DECODE.
    task automatic fetch(input logic [31:0] ins);
        instr = ins;
        #1;
        check("fetch_state", state_o, 0);
        check("fetch_memread", MemRead, 1);
        check("fetch_irwrite", IRWrite, 1);
        check("fetch_pcwrite", PCWrite, 1);
        check("fetch_pcsrc", PCSrc, 0);
        step();
        check("decode_state", state_o, 1);
    endtask

    task automatic alu_op(input logic [31:0] ins, input logic [3:0] ctrl, input logic src);
        fetch(ins);
        check("decode_immsrc", ImmSrc, 0);
        check("decode_regwrite", RegWrite, 0);
        step();
        check("exec_state", state_o, 2);
        check("exec_aluctrl", ALUControl, ctrl);
        check("exec_alusrc", ALUSrc, src);
        check("exec_regwrite", RegWrite, 0);
        step();
        check("aluwb_state", state_o, 3);
        check("aluwb_regwrite", RegWrite, 1);
        check("aluwb_aluctrl", ALUControl, ctrl);
        check("aluwb_resultsrc", ResultSrc, 0);
        step();
        check("aluop_done", state_o, 0);
    endtask

    task automatic branch(input logic [31:0] ins, input logic taken);
        fetch(ins);
        check("br_decode_imm", ImmSrc, 2);
        step();
        check("br_state", state_o, 8);
        check("br_pcwrite", PCWrite, taken);
        check("br_pcsrc", PCSrc, 1);
        check("br_aluctrl", ALUControl, 1);
        check("br_alusrc", ALUSrc, 0);
        check("br_regwrite", RegWrite, 0);
        step();
        check("br_done", state_o, 0);
    endtask

    task automatic one_cycle(input logic [31:0] ins, input logic [3:0] st, input logic [1:0] res,
                             input logic pcw, input logic [1:0] pcs, input logic [2:0] imm);
        fetch(ins);
        step();
        check("oc_state", state_o, st);
        check("oc_resultsrc", ResultSrc, res);
        check("oc_regwrite", RegWrite, 1);
        check("oc_pcwrite", PCWrite, pcw);
        check("oc_pcsrc", PCSrc, pcs);
        check("oc_immsrc", ImmSrc, imm);
        step();
        check("oc_done", state_o, 0);
    endtask

    initial begin
        do_reset();

        alu_op(32'h00500093, 4'd0, 1'b1);   // addi x1,x0,5
        alu_op(32'h40208033, 4'd1, 1'b0);   // sub
        alu_op(32'h4020D013, 4'd6, 1'b1);   // srai
        alu_op(32'h0020D013, 4'd7, 1'b1);   // srli
        alu_op(32'h40000093, 4'd0, 1'b1);   // addi with instr[30] set stays add

        // lbu with three wait cycles: the fourth MEMRD cycle sits on the timeout boundary
        fetch(32'h0040C083);
        step();
        check("lbu_memadr", state_o, 4);
        check("lbu_alusrc", ALUSrc, 1);
        check("lbu_aluctrl", ALUControl, 0);
        check("lbu_immsrc", ImmSrc, 0);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("lbu_memrd", state_o, 5);
            check("lbu_memread", MemRead, 1);
        end
        mem_ready = 1'b1;
        step();
        check("lbu_memwb", state_o, 6);
        check("lbu_regwrite", RegWrite, 1);
        check("lbu_resultsrc", ResultSrc, 1);
        check("lbu_sizemode", SizeMode, 0);
        check("lbu_loadsigned", LoadSigned, 0);
        check("lbu_nofault", fault, 0);
        step();
        check("lbu_done", state_o, 0);

        // sw x2,4(x1)
        fetch(32'h0020A223);
        check("sw_decode_imm", ImmSrc, 1);
        step();
        check("sw_memadr", state_o, 4);
        check("sw_immsrc", ImmSrc, 1);
        step();
        check("sw_memwr", state_o, 7);
        check("sw_memwrite", MemWrite, 1);
        check("sw_memread", MemRead, 0);
        check("sw_sizemode", SizeMode, 2);
        step();
        check("sw_done", state_o, 0);

        ltu = 1'b1;
        negative = 1'b0;
        branch(32'h0020E463, 1'b1);          // bltu taken
        branch(32'h0020F463, 1'b0);          // bgeu not taken
        branch(32'h0020C463, 1'b0);          // blt uses negative, not ltu
        ltu = 1'b0;
        zero = 1'b1;
        branch(32'h00208463, 1'b1);          // beq taken
        zero = 1'b0;

        one_cycle(32'h008000EF, 4'd9, 2'b10, 1'b1, 2'b01, 3'd4);   // jal
        one_cycle(32'h000080E7, 4'd10, 2'b10, 1'b1, 2'b10, 3'd0);  // jalr
        one_cycle(32'h123450B7, 4'd11, 2'b11, 1'b0, 2'b00, 3'd3);  // lui

        // trigger raised mid-instruction: finish, then stall at the boundary
        fetch(32'h00500093);
        step();
        check("trg_exec", state_o, 2);
        trigger = 1'b1;
        step();
        check("trg_aluwb", state_o, 3);
        check("trg_regwrite", RegWrite, 1);
        step();
        check("trg_fetch", state_o, 0);
        check("trg_fetch_noread", MemRead, 0);
        check("trg_fetch_noir", IRWrite, 0);
        step();
        check("trg_stall", state_o, 12);
        check("trg_stall_noread", MemRead, 0);
        step();
        check("trg_stall_hold", state_o, 12);
        trigger = 1'b0;
        #1;
        check("trg_release_noread", MemRead, 0);
        step();
        check("trg_resume", state_o, 0);
        check("trg_resume_read", MemRead, 1);

        // fetch timeout: four wait cycles then TRAP
        do_reset();
        mem_ready = 1'b0;
        #1;
        check("tmo_fetch_read", MemRead, 1);
        check("tmo_fetch_noir", IRWrite, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("tmo_waiting", state_o, 0);
        end
        step();
        check("tmo_trap", state_o, 13);
        check("tmo_fault", fault, 1);
        mem_ready = 1'b1;
        step();
        check("tmo_trap_sticky", state_o, 13);
        check("tmo_fault_sticky", fault, 1);
        check("tmo_trap_noread", MemRead, 0);

        do_reset();
        fetch(32'h0000007F);
        step();
        check("illegal_op_trap", state_o, 13);
        check("illegal_op_fault", fault, 1);

        do_reset();
        fetch(32'h0000B003);                 // load funct3 011
        step();
        check("illegal_ld_trap", state_o, 13);

        // reset asserted during writeback drops the write immediately
        do_reset();
        fetch(32'h00500093);
        step();
        step();
        check("midrst_aluwb", RegWrite, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_regwrite", RegWrite, 0);
        check("midrst_state", state_o, 0);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
